// File: rtl/run_monitor_pkg.sv
// Shared constants for the run monitor: state encoding, default parameters
// and the timing constants used by its simulation harness.
package run_monitor_pkg;

    localparam int unsigned PC_WIDTH_DEF     = 32;
    localparam int unsigned RESET_CYCLES_DEF = 1;
    localparam int unsigned HALT_WINDOW_DEF  = 4;
    localparam int unsigned CYCLE_LIMIT_DEF  = 270;
    localparam int unsigned CNT_WIDTH_DEF    = 16;

    // Reset-hold and stable counters only need to reach 255.
    localparam int unsigned AUX_CNT_WIDTH = 8;

    localparam int unsigned STATE_WIDTH = 2;
    localparam logic [STATE_WIDTH-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_WIDTH-1:0] ST_RESET = 2'd1;
    localparam logic [STATE_WIDTH-1:0] ST_RUN   = 2'd2;
    localparam logic [STATE_WIDTH-1:0] ST_DONE  = 2'd3;

    localparam int unsigned SIM_CLK_PERIOD_NS = 10;
    localparam int unsigned SIM_RST_HOLD_NS   = 70;

endpackage

// File: rtl/run_monitor_counter.sv
// Up-counter with synchronous clear, count enable and saturation at all-ones.
module run_monitor_counter
    import run_monitor_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_WIDTH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/run_monitor.sv
// Holds a core in reset, releases it, then traces pc changes until the pc
// stalls (halt) or the run exceeds its cycle budget (timeout).
module run_monitor
    import run_monitor_pkg::*;
#(
    parameter int unsigned PC_WIDTH     = PC_WIDTH_DEF,
    parameter int unsigned RESET_CYCLES = RESET_CYCLES_DEF,
    parameter int unsigned HALT_WINDOW  = HALT_WINDOW_DEF,
    parameter int unsigned CYCLE_LIMIT  = CYCLE_LIMIT_DEF,
    parameter int unsigned CNT_WIDTH    = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [PC_WIDTH-1:0]  pc,
    output logic                 core_rst,
    output logic                 running,
    output logic                 halted,
    output logic                 timeout,
    output logic                 trace_valid,
    output logic [PC_WIDTH-1:0]  trace_pc,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] change_count
);

    logic [STATE_WIDTH-1:0]   state_d,        state_q;
    logic                     core_rst_d,     core_rst_q;
    logic                     running_d,      running_q;
    logic                     halted_d,       halted_q;
    logic                     timeout_d,      timeout_q;
    logic                     trace_valid_d,  trace_valid_q;
    logic [PC_WIDTH-1:0]      trace_pc_d,     trace_pc_q;
    logic [CNT_WIDTH-1:0]     change_count_d, change_count_q;
    logic [PC_WIDTH-1:0]      prev_pc_d,      prev_pc_q;
    logic [AUX_CNT_WIDTH-1:0] stable_d,       stable_q;
    logic [AUX_CNT_WIDTH-1:0] rst_cnt_d,      rst_cnt_q;

    logic                     start_ok;
    logic                     first_run;
    logic                     pc_same;
    logic                     pc_changed;
    logic                     halt_hit;
    logic                     limit_hit;
    logic [CNT_WIDTH-1:0]     cycle_cnt;

    run_monitor_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_cycle_cnt (
        .clk_i   (clk),
        .rst_ni  (rst),
        .clr_i   (start_ok),
        .en_i    (state_q == ST_RUN),
        .count_o (cycle_cnt)
    );

    // cycle_cnt is zero only on the first RUN cycle, which just captures pc.
    assign first_run  = (cycle_cnt == '0);
    assign pc_same    = !first_run && (pc == prev_pc_q);
    assign pc_changed = !first_run && (pc != prev_pc_q);
    assign halt_hit   = pc_same && (stable_q == AUX_CNT_WIDTH'(HALT_WINDOW - 2));
    assign limit_hit  = (cycle_cnt == CNT_WIDTH'(CYCLE_LIMIT - 1));

    always_comb begin
        state_d        = state_q;
        core_rst_d     = core_rst_q;
        running_d      = running_q;
        halted_d       = halted_q;
        timeout_d      = timeout_q;
        trace_valid_d  = 1'b0;
        trace_pc_d     = trace_pc_q;
        change_count_d = change_count_q;
        prev_pc_d      = prev_pc_q;
        stable_d       = stable_q;
        rst_cnt_d      = rst_cnt_q;
        start_ok       = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    start_ok       = 1'b1;
                    state_d        = ST_RESET;
                    core_rst_d     = 1'b1;
                    running_d      = 1'b0;
                    halted_d       = 1'b0;
                    timeout_d      = 1'b0;
                    change_count_d = '0;
                    stable_d       = '0;
                    rst_cnt_d      = '0;
                end
            end
            ST_RESET: begin
                if (rst_cnt_q == AUX_CNT_WIDTH'(RESET_CYCLES - 1)) begin
                    state_d    = ST_RUN;
                    core_rst_d = 1'b0;
                    running_d  = 1'b1;
                end else begin
                    rst_cnt_d = rst_cnt_q + AUX_CNT_WIDTH'(1);
                end
            end
            ST_RUN: begin
                prev_pc_d = pc;
                if (pc_same) begin
                    stable_d = stable_q + AUX_CNT_WIDTH'(1);
                end
                // A change on the terminating cycle is dropped: DONE never pulses trace_valid.
                if (halt_hit) begin
                    state_d   = ST_DONE;
                    running_d = 1'b0;
                    halted_d  = 1'b1;
                end else if (limit_hit) begin
                    state_d   = ST_DONE;
                    running_d = 1'b0;
                    timeout_d = 1'b1;
                end else if (pc_changed) begin
                    trace_valid_d = 1'b1;
                    trace_pc_d    = pc;
                    stable_d      = '0;
                    if (change_count_q != {CNT_WIDTH{1'b1}}) begin
                        change_count_d = change_count_q + CNT_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            core_rst_q     <= 1'b1;
            running_q      <= 1'b0;
            halted_q       <= 1'b0;
            timeout_q      <= 1'b0;
            trace_valid_q  <= 1'b0;
            trace_pc_q     <= '0;
            change_count_q <= '0;
            prev_pc_q      <= '0;
            stable_q       <= '0;
            rst_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            core_rst_q     <= core_rst_d;
            running_q      <= running_d;
            halted_q       <= halted_d;
            timeout_q      <= timeout_d;
            trace_valid_q  <= trace_valid_d;
            trace_pc_q     <= trace_pc_d;
            change_count_q <= change_count_d;
            prev_pc_q      <= prev_pc_d;
            stable_q       <= stable_d;
            rst_cnt_q      <= rst_cnt_d;
        end
    end

    assign core_rst     = core_rst_q;
    assign running      = running_q;
    assign halted       = halted_q;
    assign timeout      = timeout_q;
    assign trace_valid  = trace_valid_q;
    assign trace_pc     = trace_pc_q;
    assign cycle_count  = cycle_cnt;
    assign change_count = change_count_q;

endmodule

// File: tb/tb_run_monitor.sv
// Scoreboard bench for run_monitor: a default instance and a short-budget
// instance share stimulus; a sample-history model predicts every cycle.
module tb_run_monitor;
    import run_monitor_pkg::*;

    typedef struct packed {
        logic        core_rst;
        logic        running;
        logic        halted;
        logic        timeout;
        logic        trace_valid;
        logic [31:0] trace_pc;
        logic [15:0] cycle_count;
        logic [15:0] change_count;
    } obs_t;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic        start = 1'b0;
    logic [31:0] pc    = '0;

    logic a_core_rst, a_running, a_halted, a_timeout, a_trace_valid;
    logic b_core_rst, b_running, b_halted, b_timeout, b_trace_valid;
    logic [31:0] a_trace_pc, b_trace_pc;
    logic [15:0] a_cycle_count, a_change_count, b_cycle_count, b_change_count;
    obs_t obs_a, obs_b;

    int checks = 0;
    int errors = 0;

    always #(SIM_CLK_PERIOD_NS / 2) clk = ~clk;

    run_monitor u_a (
        .clk(clk), .rst(rst), .start(start), .pc(pc),
        .core_rst(a_core_rst), .running(a_running), .halted(a_halted), .timeout(a_timeout),
        .trace_valid(a_trace_valid), .trace_pc(a_trace_pc),
        .cycle_count(a_cycle_count), .change_count(a_change_count)
    );

    run_monitor #(.RESET_CYCLES(3), .HALT_WINDOW(10), .CYCLE_LIMIT(10)) u_b (
        .clk(clk), .rst(rst), .start(start), .pc(pc),
        .core_rst(b_core_rst), .running(b_running), .halted(b_halted), .timeout(b_timeout),
        .trace_valid(b_trace_valid), .trace_pc(b_trace_pc),
        .cycle_count(b_cycle_count), .change_count(b_change_count)
    );

    assign obs_a = {a_core_rst, a_running, a_halted, a_timeout, a_trace_valid,
                    a_trace_pc, a_cycle_count, a_change_count};
    assign obs_b = {b_core_rst, b_running, b_halted, b_timeout, b_trace_valid,
                    b_trace_pc, b_cycle_count, b_change_count};

    // Instance parameters as the model sees them (spec defaults for instance 0).
    function automatic int p_rc(int k); return (k == 0) ? 1   : 3;  endfunction
    function automatic int p_hw(int k); return (k == 0) ? 4   : 10; endfunction
    function automatic int p_cl(int k); return (k == 0) ? 270 : 10; endfunction

    // Model: phase 0 idle, 1 core held in reset, 2 run, 3 done.
    int          m_ph   [2];
    int          m_rcnt [2];
    int          m_samp [2];
    int          m_same [2];
    logic [31:0] m_last [2];
    obs_t        m_o    [2];

    obs_t        st_q0[$], st_q1[$];
    logic [31:0] tr_q0[$], tr_q1[$];

    task automatic push_st(input int k, input obs_t o);
        if (k == 0) st_q0.push_back(o); else st_q1.push_back(o);
    endtask

    task automatic model_reset(input int k);
        m_ph[k] = 0; m_rcnt[k] = 0; m_samp[k] = 0; m_same[k] = 0; m_last[k] = '0;
        m_o[k] = '0;
        m_o[k].core_rst = 1'b1;
    endtask

    task automatic model_edge(input int k, input logic s, input logic [31:0] p);
        obs_t o;
        bit   changed;
        o = m_o[k];
        o.trace_valid = 1'b0;
        case (m_ph[k])
            0, 3: if (s) begin
                m_ph[k] = 1; m_rcnt[k] = 0; m_samp[k] = 0; m_same[k] = 0;
                o.core_rst = 1'b1; o.running = 1'b0; o.halted = 1'b0; o.timeout = 1'b0;
                o.cycle_count = '0; o.change_count = '0;
            end
            1: begin
                m_rcnt[k]++;
                if (m_rcnt[k] == p_rc(k)) begin
                    m_ph[k] = 2; o.core_rst = 1'b0; o.running = 1'b1;
                end
            end
            default: begin
                m_samp[k]++;
                o.cycle_count = (m_samp[k] > 65535) ? 16'hffff : 16'(m_samp[k]);
                changed = (m_samp[k] > 1) && (p != m_last[k]);
                if (m_samp[k] == 1 || changed) m_same[k] = 1; else m_same[k]++;
                m_last[k] = p;
                if (m_same[k] == p_hw(k)) begin
                    m_ph[k] = 3; o.running = 1'b0; o.halted = 1'b1;
                end else if (m_samp[k] == p_cl(k)) begin
                    m_ph[k] = 3; o.running = 1'b0; o.timeout = 1'b1;
                end else if (changed) begin
                    o.trace_valid = 1'b1;
                    o.trace_pc    = p;
                    if (o.change_count != 16'hffff) o.change_count = o.change_count + 16'd1;
                    if (k == 0) tr_q0.push_back(p); else tr_q1.push_back(p);
                end
            end
        endcase
        m_o[k] = o;
        push_st(k, o);
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) model_reset(k);
            st_q0.delete(); st_q1.delete(); tr_q0.delete(); tr_q1.delete();
            push_st(0, m_o[0]);
            push_st(1, m_o[1]);
        end else begin
            for (int k = 0; k < 2; k++) model_edge(k, start, pc);
        end
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%0h expected=%0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic check_dut(input int k, input obs_t act);
        obs_t        exp;
        logic [31:0] tp;
        int          n;
        n = (k == 0) ? st_q0.size() : st_q1.size();
        if (n == 0) begin
            chk("no_expectation", k, 32'd0, 32'd1);
        end else begin
            exp = (k == 0) ? st_q0.pop_front() : st_q1.pop_front();
            chk("core_rst",     k, 32'(act.core_rst),     32'(exp.core_rst));
            chk("running",      k, 32'(act.running),      32'(exp.running));
            chk("halted",       k, 32'(act.halted),       32'(exp.halted));
            chk("timeout",      k, 32'(act.timeout),      32'(exp.timeout));
            chk("trace_valid",  k, 32'(act.trace_valid),  32'(exp.trace_valid));
            chk("trace_pc",     k, act.trace_pc,          exp.trace_pc);
            chk("cycle_count",  k, 32'(act.cycle_count),  32'(exp.cycle_count));
            chk("change_count", k, 32'(act.change_count), 32'(exp.change_count));
        end
        if (act.trace_valid === 1'b1) begin
            n = (k == 0) ? tr_q0.size() : tr_q1.size();
            if (n == 0) begin
                chk("unexpected_trace", k, act.trace_pc, 32'hxxxx_xxxx);
            end else begin
                tp = (k == 0) ? tr_q0.pop_front() : tr_q1.pop_front();
                chk("trace_event", k, act.trace_pc, tp);
            end
        end
    endtask

    always @(negedge clk) begin
        check_dut(0, obs_a);
        check_dut(1, obs_b);
    end

    // One active edge with the given inputs; returns 1 time unit after it.
    task automatic cyc(input logic s, input logic [31:0] p);
        start = s;
        pc    = p;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        logic [31:0] cur;
        int          mode;
        int          len;

        repeat (7) cyc(1'b0, 32'd0);
        rst = 1'b1;

        // Start honoured on the first edge after reset release; pc 0,4,8 then holds.
        cyc(1'b1, 32'd0);
        cyc(1'b0, 32'd0);
        cyc(1'b0, 32'd0);
        cyc(1'b0, 32'd4);
        cyc(1'b0, 32'd8);
        repeat (3) cyc(1'b0, 32'd8);
        @(negedge clk);
        chk("s1_halted",   0, 32'(a_halted),       32'd1);
        chk("s1_timeout",  0, 32'(a_timeout),      32'd0);
        chk("s1_changes",  0, 32'(a_change_count), 32'd2);
        chk("s1_trace_pc", 0, a_trace_pc,          32'd8);
        chk("s1_core_rst", 0, 32'(a_core_rst),     32'd0);
        repeat (8) cyc(1'b0, 32'd8);

        // Restart from DONE clears halted on the same edge; a start mid-RUN is ignored.
        cyc(1'b1, 32'd8);
        @(negedge clk);
        chk("s2_halt_clr", 0, 32'(a_halted),   32'd0);
        chk("s2_core_rst", 0, 32'(a_core_rst), 32'd1);
        for (int i = 0; i < 16; i++) cyc(i == 6, 32'(100 + 4 * i));
        @(negedge clk);
        chk("s2_timeout",  1, 32'(b_timeout),     32'd1);
        chk("s2_halted",   1, 32'(b_halted),      32'd0);
        chk("s2_cycles",   1, 32'(b_cycle_count), 32'd10);
        chk("s2_running",  0, 32'(a_running),     32'd1);
        repeat (5) cyc(1'b0, 32'd200);

        // Three-cycle core reset, then halt coinciding with the cycle limit.
        cyc(1'b1, 32'd300);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("s3_core_rst_hold", 1, 32'(b_core_rst), 32'd1);
            chk("s3_not_running",   1, 32'(b_running),  32'd0);
            cyc(1'b0, 32'd300);
        end
        @(negedge clk);
        chk("s3_core_rst_rel", 1, 32'(b_core_rst), 32'd0);
        chk("s3_running",      1, 32'(b_running),  32'd1);
        repeat (12) cyc(1'b0, 32'd300);
        @(negedge clk);
        chk("s3_halted",  1, 32'(b_halted),      32'd1);
        chk("s3_timeout", 1, 32'(b_timeout),     32'd0);
        chk("s3_cycles",  1, 32'(b_cycle_count), 32'd10);

        // Asynchronous abort mid-RUN, then the block idles until a new start.
        cyc(1'b1, 32'd0);
        for (int i = 1; i < 7; i++) cyc(1'b0, 32'(i * 4));
        rst = 1'b0;
        #1;
        chk("s5_core_rst", 0, 32'(a_core_rst),     32'd1);
        chk("s5_running",  0, 32'(a_running),      32'd0);
        chk("s5_cycles",   0, 32'(a_cycle_count),  32'd0);
        chk("s5_changes",  0, 32'(a_change_count), 32'd0);
        chk("s5_trace_pc", 0, a_trace_pc,          32'd0);
        cyc(1'b1, 32'd0);
        cyc(1'b1, 32'd0);
        rst = 1'b1;
        repeat (3) cyc(1'b0, 32'd0);
        @(negedge clk);
        chk("s5_idle_rst", 0, 32'(a_core_rst), 32'd1);
        chk("s5_idle_run", 0, 32'(a_running),  32'd0);

        // Full-length run on the default instance reaches its cycle limit.
        cyc(1'b1, 32'd0);
        for (int i = 1; i < 276; i++) cyc(1'b0, 32'(i));
        @(negedge clk);
        chk("s6_timeout", 0, 32'(a_timeout),     32'd1);
        chk("s6_halted",  0, 32'(a_halted),      32'd0);
        chk("s6_cycles",  0, 32'(a_cycle_count), 32'd270);

        // Random runs: stepping, mostly-held and small-alphabet pc traces.
        cur = '0;
        for (int n = 0; n < 40; n++) begin
            mode = int'($urandom_range(0, 2));
            len  = int'($urandom_range(4, 30));
            cur  = $urandom;
            cyc(1'b1, cur);
            for (int j = 0; j < len; j++) begin
                case (mode)
                    0:       cur = cur + 32'd4;
                    1:       if ($urandom_range(0, 3) == 0) cur = 32'($urandom_range(0, 7));
                    default: cur = 32'($urandom_range(0, 3)) * 32'd4;
                endcase
                if ($urandom_range(0, 49) == 0) begin
                    rst = 1'b0;
                    cyc($urandom_range(0, 9) == 0, cur);
                    rst = 1'b1;
                end else begin
                    cyc($urandom_range(0, 9) == 0, cur);
                end
            end
        end

        repeat (3) cyc(1'b0, 32'd0);
        @(negedge clk);
        chk("trace_drained", 0, 32'(tr_q0.size()), 32'd0);
        chk("trace_drained", 1, 32'(tr_q1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
